// File: rtl/switch_debounce_ctrl_pkg.sv
// Shared types and defaults for the switch debounce controller.
// The state enum is used by the controller FSM; the default window length is used by both modules.
package switch_debounce_ctrl_pkg;

   typedef enum logic [1:0] {
      STABLE  = 2'd0,
      COUNT   = 2'd1,
      PRESENT = 2'd2
   } state_t;

   localparam int DEFAULT_STABLE_CYCLES = 4;

endpackage

// File: rtl/switch_debounce_ctrl_debounce_timer.sv
// Stability window counter: clear restarts the window, enable advances it.
// tc flags the last sample of the window.
module debounce_timer
   import switch_debounce_ctrl_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CNT_LAST);

endmodule

// File: rtl/switch_debounce_ctrl.sv
// Debounces a pre-synchronized switch bus and offers each new settled value
// downstream through a valid/ready handshake, counting completed handshakes.
module switch_debounce_ctrl
   import switch_debounce_ctrl_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sync_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic [7:0]       event_count
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] committed_q, committed_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       event_count_q, event_count_d;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_tc;

   debounce_timer #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_timer (
      .clk  (clk),
      .reset(reset),
      .clr  (tmr_clr),
      .en   (tmr_en),
      .tc   (tmr_tc)
   );

   always_comb begin
      state_d       = state_q;
      committed_d   = committed_q;
      cand_d        = cand_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      event_count_d = event_count_q;
      tmr_clr       = 1'b0;
      tmr_en        = 1'b0;

      case (state_q)
         STABLE: begin
            if (sync_in != committed_q) begin
               cand_d  = sync_in;
               tmr_clr = 1'b1;
               state_d = COUNT;
            end
         end
         COUNT: begin
            // Any bounce restarts the window on the new candidate.
            if (sync_in != cand_q) begin
               cand_d  = sync_in;
               tmr_clr = 1'b1;
            end else if (!tmr_tc) begin
               tmr_en = 1'b1;
            end else if (cand_q == committed_q) begin
               state_d = STABLE;
            end else begin
               out_data_d  = cand_q;
               out_valid_d = 1'b1;
               state_d     = PRESENT;
            end
         end
         PRESENT: begin
            // sync_in is deliberately ignored here; STABLE picks up any change afterwards.
            if (out_ready) begin
               committed_d   = out_data_q;
               out_valid_d   = 1'b0;
               event_count_d = event_count_q + 8'd1;
               state_d       = STABLE;
            end
         end
         default: begin
            state_d = STABLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= STABLE;
         committed_q   <= '0;
         cand_q        <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         event_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         committed_q   <= committed_d;
         cand_q        <= cand_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         event_count_q <= event_count_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign event_count = event_count_q;
   assign busy        = (state_q != STABLE);

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl (WIDTH=16, STABLE_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_switch_debounce_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] sync_in;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        busy;
   logic [7:0]  event_count;

   int n_cmp;
   int n_bad;

   switch_debounce_ctrl #(
      .WIDTH        (16),
      .STABLE_CYCLES(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sync_in    (sync_in),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .busy       (busy),
      .event_count(event_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until out_valid is seen; returns the tick count, or -1 if the budget expires.
   task automatic wait_valid(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!out_valid && n < budget);
      if (!out_valid) n = -1;
   endtask

   initial begin
      int n;
      int wrap_bad;
      n_cmp     = 0;
      n_bad     = 0;
      wrap_bad  = 0;
      reset     = 1'b1;
      sync_in   = 16'h0000;
      out_ready = 1'b0;

      // Reset state
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_data", 32'(out_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_count", 32'(event_count), 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // Clean change: valid 4 edges after the first edge that sees the new value
      sync_in   = 16'h00A5;
      out_ready = 1'b1;
      wait_valid(12, n);
      check_eq("clean_lat", 32'(n), 32'd5);
      check_eq("clean_data", 32'(out_data), 32'h00A5);
      tick();
      check_eq("clean_valid_drop", 32'(out_valid), 32'd0);
      check_eq("clean_count", 32'(event_count), 32'd1);
      check_eq("clean_busy", 32'(busy), 32'd0);

      // Re-reset so the bounce starts from committed 0
      reset = 1'b1;
      #1;
      check_eq("rerst_count", 32'(event_count), 32'd0);
      tick();
      reset = 1'b0;

      // Bounce: 1,1,0,0,... for 10 cycles, then hold 1
      for (int i = 0; i < 10; i++) begin
         sync_in = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
         tick();
         check_eq($sformatf("bounce_novalid_%0d", i), 32'(out_valid), 32'd0);
      end
      wait_valid(12, n);
      check_eq("bounce_lat", 32'(n), 32'd3);
      check_eq("bounce_data", 32'(out_data), 32'h0001);
      tick();
      check_eq("bounce_count", 32'(event_count), 32'd1);

      // Commit 0 again before the glitch test
      sync_in = 16'h0000;
      wait_valid(12, n);
      check_eq("commit0_lat", 32'(n), 32'd5);
      tick();
      check_eq("commit0_count", 32'(event_count), 32'd2);

      // Glitch: one-cycle pulse returns to committed value without an event
      sync_in = 16'h0008;
      tick();
      sync_in = 16'h0000;
      check_eq("glitch_busy_1", 32'(busy), 32'd1);
      for (int k = 2; k <= 8; k++) begin
         tick();
         check_eq($sformatf("glitch_valid_%0d", k), 32'(out_valid), 32'd0);
         check_eq($sformatf("glitch_busy_%0d", k), 32'(busy), (k <= 5) ? 32'd1 : 32'd0);
      end
      check_eq("glitch_count", 32'(event_count), 32'd2);

      // Backpressure: first value held while sync_in keeps moving
      out_ready = 1'b0;
      sync_in   = 16'hFFFF;
      wait_valid(12, n);
      check_eq("bp_lat", 32'(n), 32'd5);
      sync_in = 16'h1234;
      for (int k = 0; k < 20; k++) tick();
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_data", 32'(out_data), 32'hFFFF);
      check_eq("bp_hold_count", 32'(event_count), 32'd2);
      out_ready = 1'b1;
      wait_valid(12, n);
      check_eq("bp_second_lat", 32'(n), 32'd6);
      check_eq("bp_second_data", 32'(out_data), 32'h1234);
      check_eq("bp_count_mid", 32'(event_count), 32'd3);
      tick();
      check_eq("bp_count", 32'(event_count), 32'd4);

      // Wrap: 252 more handshakes bring the total to 256
      for (int i = 0; i < 252; i++) begin
         sync_in = (i % 2 == 0) ? 16'h5555 : 16'hAAAA;
         wait_valid(12, n);
         if (n != 5) wrap_bad++;
         tick();
         if (i == 250) check_eq("wrap_255", 32'(event_count), 32'd255);
      end
      check_eq("wrap_lat_errors", 32'(wrap_bad), 32'd0);
      check_eq("wrap_zero", 32'(event_count), 32'd0);

      // Reset mid-PRESENT drops outputs before any clock edge
      out_ready = 1'b0;
      sync_in   = 16'h00F0;
      wait_valid(12, n);
      check_eq("prst_lat", 32'(n), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      check_eq("prst_valid", 32'(out_valid), 32'd0);
      check_eq("prst_data", 32'(out_data), 32'd0);
      check_eq("prst_busy", 32'(busy), 32'd0);
      check_eq("prst_count", 32'(event_count), 32'd0);
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;

      // Nonzero input after reset is debounced as a change from 0
      wait_valid(12, n);
      check_eq("post_rst_lat", 32'(n), 32'd5);
      check_eq("post_rst_data", 32'(out_data), 32'h00F0);
      tick();
      check_eq("post_rst_count", 32'(event_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
